iob_bus_sel_ctrl: RTL
=====================

IOB_BUS_SEL_CTRL -- requirements
Module: iob_bus_sel_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter N, default 2, number of followers, minimum 2.
REQ-004 Parameter NB, default $clog2(N), selection width.
REQ-005 Parameter MAX_OUT, default 4, maximum outstanding reads, minimum 1; CNT_W = $clog2(MAX_OUT+1).
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  clock, all state updates on rising edge.
REQ-008 cke_i  in  1  clock enable; state holds when low.
REQ-009 rst_i  in  1  synchronous active-high reset.
REQ-010 Manager side: m_valid_i in 1, m_addr_i in ADDR_W, m_wdata_i in DATA_W, m_wstrb_i in DATA_W/8, m_rdata_o out DATA_W, m_rvalid_o out 1, m_ready_o out 1; IOb native request/response.
REQ-011 Downstream side (to bus demux): d_valid_o out 1, d_addr_o out ADDR_W, d_wdata_o out DATA_W, d_wstrb_o out DATA_W/8, d_rdata_i in DATA_W, d_rvalid_i in 1, d_ready_i in 1.
REQ-012 d_sel_o  out  NB  follower selection fed to the demux f_sel_i.
REQ-013 busy_o  out  1  high while outstanding read count is nonzero.
REQ-014 err_o  out  1  sticky: response received with no outstanding read.

Function
REQ-015 Decoded selection dsel = m_addr_i[ADDR_W-1 -: NB]; values >= N clamp to N-1; d_sel_o = dsel combinationally.
REQ-016 d_addr_o, d_wdata_o, d_wstrb_o pass m_addr_i, m_wdata_i, m_wstrb_i unchanged; m_rdata_o = d_rdata_i, m_rvalid_o = d_rvalid_i, zero added latency.
REQ-017 Request is a read when m_wstrb_i == 0, else a write; writes produce no rvalid and are not counted.
REQ-018 State: cnt (CNT_W bits, outstanding reads), sel_r (NB bits, follower of last accepted request).
REQ-019 stall = (cnt != 0 and dsel != sel_r) or (read request and cnt == MAX_OUT and d_rvalid_i == 0).
REQ-020 A write to a different follower while cnt != 0 also stalls (per REQ-019); same-follower writes pass.
REQ-021 d_valid_o = m_valid_i and not stall; m_ready_o = d_ready_i and not stall.
REQ-022 Accept = d_valid_o and d_ready_i; on accept sel_r <= dsel.
REQ-023 cnt next = cnt + (accepted read) - (d_rvalid_i and cnt != 0); simultaneous accept and rvalid leaves cnt unchanged.
REQ-024 cnt never exceeds MAX_OUT nor wraps below 0.
REQ-025 d_rvalid_i with cnt == 0 sets err_o; cnt stays 0; err_o clears only by reset.
REQ-026 busy_o = (cnt != 0), registered-state derived, no combinational path from inputs.
REQ-027 When cke_i = 0, cnt, sel_r, err_o hold; combinational paths remain active.

Reset
REQ-028 rst_i high at a clock edge sets cnt = 0, sel_r = 0, err_o = 0, thus busy_o = 0.
REQ-029 Reset mid-transaction discards outstanding count; later stray rvalid sets err_o.
REQ-030 During reset cycle combinational outputs follow inputs; no request is tracked.

Verification
REQ-031 N=4, ADDR_W=32: read addr 0x4000_0000, ready=1 -> d_sel_o=1, d_valid_o=1, cnt=1 next cycle, busy_o=1.
REQ-032 cnt=1 to follower 1, read to 0x8000_0000 -> d_valid_o=0, m_ready_o=0 until rvalid; cycle after rvalid, request passes with d_sel_o=2.
REQ-033 MAX_OUT=2, three back-to-back reads to follower 0 -> third stalls while cnt=2; rvalid in same cycle lets it pass, cnt stays 2.
REQ-034 Write (wstrb=0xF) to follower 3 with cnt=0 -> passes, cnt stays 0, sel_r=3.
REQ-035 rvalid with cnt=0 -> err_o=1 next cycle and remains 1 until rst_i.
REQ-036 rst_i asserted with cnt=2 -> cnt=0, busy_o=0, sel_r=0 next cycle; cke_i=0 with accepted read -> cnt unchanged.

Source files
------------

// File: rtl/iob_bus_sel_ctrl.sv
// Follower-selection controller in front of an IOb bus demux: decodes the follower from the
// top address bits and holds off requests that would let read responses come back out of order.
module iob_bus_sel_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N       = 2,
  parameter int NB      = $clog2(N),
  parameter int MAX_OUT = 4
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  // manager side
  input  logic                m_valid_i,
  input  logic [ADDR_W-1:0]   m_addr_i,
  input  logic [DATA_W-1:0]   m_wdata_i,
  input  logic [DATA_W/8-1:0] m_wstrb_i,
  output logic [DATA_W-1:0]   m_rdata_o,
  output logic                m_rvalid_o,
  output logic                m_ready_o,
  // downstream side
  output logic                d_valid_o,
  output logic [ADDR_W-1:0]   d_addr_o,
  output logic [DATA_W-1:0]   d_wdata_o,
  output logic [DATA_W/8-1:0] d_wstrb_o,
  input  logic [DATA_W-1:0]   d_rdata_i,
  input  logic                d_rvalid_i,
  input  logic                d_ready_i,
  output logic [NB-1:0]       d_sel_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0]    CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(MAX_OUT);
  localparam logic [DATA_W/8-1:0] WSTRB_ZERO = {(DATA_W/8){1'b0}};

  // Address codes beyond the last follower are folded onto the last follower.
  function automatic logic [NB-1:0] clamp_sel(input logic [NB-1:0] raw);
    logic [NB-1:0] res;
    if ({1'b0, raw} >= (NB+1)'(N)) begin
      res = NB'(N - 1);
    end else begin
      res = raw;
    end
    return res;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [NB-1:0]    sel_r;
  logic [NB-1:0]    sel_nxt_s;
  logic             err_r;
  logic             err_nxt_s;
  logic             busy_r;
  logic [NB-1:0]    dsel_s;
  logic             is_read_s;
  logic             stall_s;
  logic             accept_s;
  logic             acc_read_s;
  logic             resp_dec_s;

  // Decode, stall and handshake qualification.
  always_comb begin
    dsel_s     = clamp_sel(m_addr_i[ADDR_W-1 -: NB]);
    is_read_s  = (m_wstrb_i == WSTRB_ZERO);
    stall_s    = ((cnt_r != CNT_ZERO) && (dsel_s != sel_r)) ||
                 (is_read_s && (cnt_r == CNT_MAX) && !d_rvalid_i);
    accept_s   = m_valid_i && !stall_s && d_ready_i;
    acc_read_s = accept_s && is_read_s;
    resp_dec_s = d_rvalid_i && (cnt_r != CNT_ZERO);
  end

  // Next-state for outstanding count, last follower and sticky error.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({acc_read_s, resp_dec_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
    if (accept_s) begin
      sel_nxt_s = dsel_s;
    end else begin
      sel_nxt_s = sel_r;
    end
    // A response with nothing outstanding is a protocol violation downstream.
    if (d_rvalid_i && (cnt_r == CNT_ZERO)) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // State register; reset wins over the clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r  <= CNT_ZERO;
      sel_r  <= {NB{1'b0}};
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else if (cke_i) begin
      cnt_r  <= cnt_nxt_s;
      sel_r  <= sel_nxt_s;
      err_r  <= err_nxt_s;
      busy_r <= (cnt_nxt_s != CNT_ZERO);
    end
  end

  // Zero-latency pass-through paths and output mapping.
  always_comb begin
    d_sel_o    = dsel_s;
    d_valid_o  = m_valid_i && !stall_s;
    m_ready_o  = d_ready_i && !stall_s;
    d_addr_o   = m_addr_i;
    d_wdata_o  = m_wdata_i;
    d_wstrb_o  = m_wstrb_i;
    m_rdata_o  = d_rdata_i;
    m_rvalid_o = d_rvalid_i;
    busy_o     = busy_r;
    err_o      = err_r;
  end

endmodule
